// File: rtl/csr_pkg.sv
// Shared CSR numbering, field positions and helpers for the privileged CSR block.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int unsigned CRMD_PLV_LSB     = 32'd0;
  localparam int unsigned CRMD_IE          = 32'd2;
  localparam int unsigned ESTAT_SWI_LSB    = 32'd0;
  localparam int unsigned ESTAT_HWI_LSB    = 32'd2;
  localparam int unsigned ESTAT_TI         = 32'd11;
  localparam int unsigned ESTAT_IPI        = 32'd12;
  localparam int unsigned ESTAT_ECODE_LSB  = 32'd16;
  localparam int unsigned ESTAT_ESUB_LSB   = 32'd22;
  localparam int unsigned EENTRY_VA_LSB    = 32'd6;
  localparam int unsigned TCFG_EN          = 32'd0;
  localparam int unsigned TCFG_PERIODIC    = 32'd1;
  localparam int unsigned TCFG_INITVAL_LSB = 32'd2;
  localparam int unsigned TICLR_CLR        = 32'd0;

  // IS[10] has no source, so its enable is never kept
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1bff;

  typedef struct packed {
    logic       ie;
    logic [1:0] plv;
  } mode_t;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (old_v & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: TCFG register, down counter and the IS[11] timer-interrupt flag.
module csr_timer
  import csr_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcfg_we,
  input  logic        ticlr_we,
  input  logic [31:0] wmask,
  input  logic [31:0] wvalue,
  output logic [31:0] tcfg_rvalue,
  output logic [31:0] tval_rvalue,
  output logic        ti_flag
);

  localparam logic [TIMER_WIDTH-1:0] CNT_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  logic                          en_q, en_d;
  logic                          per_q, per_d;
  logic [TIMER_WIDTH-1:2]        init_q, init_d;
  logic [TIMER_WIDTH-1:0]        cnt_q, cnt_d;
  logic                          ti_q, ti_d;
  logic [31:0]                   tcfg_wr_s;
  logic                          fire_s;
  logic                          clr_s;

  assign tcfg_rvalue = 32'({init_q, per_q, en_q});
  assign tval_rvalue = 32'(cnt_q);
  assign ti_flag     = ti_q;

  // Next-state for config, counter and interrupt flag; a timer set beats a TICLR clear
  always_comb begin
    tcfg_wr_s = csr_merge(tcfg_rvalue, wmask, wvalue);
    clr_s     = ticlr_we & wmask[TICLR_CLR] & wvalue[TICLR_CLR];
    en_d      = en_q;
    per_d     = per_q;
    init_d    = init_q;
    cnt_d     = cnt_q;
    fire_s    = 1'b0;
    if (tcfg_we) begin
      en_d   = tcfg_wr_s[TCFG_EN];
      per_d  = tcfg_wr_s[TCFG_PERIODIC];
      init_d = tcfg_wr_s[TIMER_WIDTH-1:TCFG_INITVAL_LSB];
      cnt_d  = {init_d, 2'b00};
    end else if (en_q) begin
      if (cnt_q != {TIMER_WIDTH{1'b0}}) begin
        cnt_d  = cnt_q - CNT_ONE;
        fire_s = (cnt_q == CNT_ONE);
      end else if (per_q && (init_q != {(TIMER_WIDTH-2){1'b0}})) begin
        // A zero InitVal never reloads, so periodic mode cannot re-fire from zero
        cnt_d = {init_q, 2'b00};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (fire_s) begin
      ti_d = 1'b1;
    end else if (clr_s) begin
      ti_d = 1'b0;
    end else begin
      ti_d = ti_q;
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      per_q  <= 1'b0;
      init_q <= {(TIMER_WIDTH-2){1'b0}};
      cnt_q  <= {TIMER_WIDTH{1'b0}};
      ti_q   <= 1'b0;
    end else begin
      en_q   <= en_d;
      per_q  <= per_d;
      init_q <= init_d;
      cnt_q  <= cnt_d;
      ti_q   <= ti_d;
    end
  end

endmodule

// File: rtl/csr_ctrl.sv
// Privileged CSR file: mode/exception state, interrupt status, scratch registers and timer.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int          HW_INT_NUM  = 8,
  parameter int          TIMER_WIDTH = 32,
  parameter int          SAVE_NUM    = 4,
  parameter logic [31:0] CORE_ID     = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic [HW_INT_NUM-1:0] hw_int_in,
  input  logic                  ipi_int_in,
  input  logic                  wb_ex,
  input  logic [5:0]            wb_ecode,
  input  logic [8:0]            wb_esubcode,
  input  logic [31:0]           wb_pc,
  input  logic                  wb_badv_we,
  input  logic [31:0]           wb_vaddr,
  input  logic                  ertn_flush,
  output logic [31:0]           ex_entry,
  output logic [31:0]           ertn_pc,
  output logic                  has_int
);

  mode_t                 crmd_q, crmd_d;
  mode_t                 prmd_q, prmd_d;
  logic [12:0]           lie_q, lie_d;
  logic [1:0]            is_sw_q, is_sw_d;
  logic [HW_INT_NUM-1:0] hwi_q, hwi_d;
  logic                  ipi_q, ipi_d;
  logic [5:0]            ecode_q, ecode_d;
  logic [8:0]            esub_q, esub_d;
  logic [31:0]           era_q, era_d;
  logic [31:0]           badv_q, badv_d;
  logic [31:6]           eentry_q, eentry_d;
  logic [31:0]           tid_q, tid_d;
  logic [31:0]           save_q [SAVE_NUM];
  logic [31:0]           save_d [SAVE_NUM];

  logic [12:0]           is_s;
  logic                  ti_s;
  logic [31:0]           tcfg_rd_s;
  logic [31:0]           tval_rd_s;
  logic [31:0]           save_rd_s;
  logic [31:0]           rd_mux_s;
  logic [31:0]           wr_s;

  csr_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tcfg_we    (csr_we && (csr_num == CSR_TCFG)),
    .ticlr_we   (csr_we && (csr_num == CSR_TICLR)),
    .wmask      (csr_wmask),
    .wvalue     (csr_wvalue),
    .tcfg_rvalue(tcfg_rd_s),
    .tval_rvalue(tval_rd_s),
    .ti_flag    (ti_s)
  );

  // Assemble ESTAT.IS from its individual sources
  always_comb begin
    is_s = 13'h0;
    is_s[ESTAT_SWI_LSB +: 2]          = is_sw_q;
    is_s[ESTAT_HWI_LSB +: HW_INT_NUM] = hwi_q;
    is_s[ESTAT_TI]                    = ti_s;
    is_s[ESTAT_IPI]                   = ipi_q;
  end

  // Register view selected by csr_num; also the base for masked writes
  always_comb begin
    save_rd_s = 32'h0;
    for (int i = 0; i < SAVE_NUM; i++) begin
      save_rd_s = (csr_num == (CSR_SAVE0 + 14'(i))) ? save_q[i] : save_rd_s;
    end
    case (csr_num)
      CSR_CRMD:   rd_mux_s = {23'h0, 2'b00, 2'b00, 1'b0, 1'b1, crmd_q.ie, crmd_q.plv};
      CSR_PRMD:   rd_mux_s = {29'h0, prmd_q.ie, prmd_q.plv};
      CSR_ECFG:   rd_mux_s = {19'h0, lie_q};
      CSR_ESTAT:  rd_mux_s = {1'b0, esub_q, ecode_q, 3'b000, is_s};
      CSR_ERA:    rd_mux_s = era_q;
      CSR_BADV:   rd_mux_s = badv_q;
      CSR_EENTRY: rd_mux_s = {eentry_q, 6'h00};
      CSR_TID:    rd_mux_s = tid_q;
      CSR_TCFG:   rd_mux_s = tcfg_rd_s;
      CSR_TVAL:   rd_mux_s = tval_rd_s;
      default:    rd_mux_s = save_rd_s;
    endcase
  end

  assign wr_s       = csr_merge(rd_mux_s, csr_wmask, csr_wvalue);
  assign csr_rvalue = csr_re ? rd_mux_s : 32'h0;
  assign ex_entry   = {eentry_q, 6'h00};
  assign ertn_pc    = era_q;
  assign has_int    = crmd_q.ie & (|(is_s & lie_q));

  // Next-state: exception commit beats ertn, which beats software writes
  always_comb begin
    crmd_d  = crmd_q;
    prmd_d  = prmd_q;
    era_d   = era_q;
    ecode_d = ecode_q;
    esub_d  = esub_q;
    hwi_d   = hw_int_in;
    ipi_d   = ipi_int_in;
    if (wb_ex) begin
      prmd_d     = crmd_q;
      crmd_d.plv = 2'b00;
      crmd_d.ie  = 1'b0;
      era_d      = wb_pc;
      ecode_d    = wb_ecode;
      esub_d     = wb_esubcode;
    end else if (ertn_flush) begin
      crmd_d = prmd_q;
    end else begin
      if (csr_we && (csr_num == CSR_CRMD)) begin
        crmd_d.plv = wr_s[CRMD_PLV_LSB +: 2];
        crmd_d.ie  = wr_s[CRMD_IE];
      end else begin
        crmd_d = crmd_q;
      end
      if (csr_we && (csr_num == CSR_PRMD)) begin
        prmd_d.plv = wr_s[CRMD_PLV_LSB +: 2];
        prmd_d.ie  = wr_s[CRMD_IE];
      end else begin
        prmd_d = prmd_q;
      end
      era_d   = (csr_we && (csr_num == CSR_ERA)) ? wr_s : era_q;
      ecode_d = (csr_we && (csr_num == CSR_ESTAT)) ? wr_s[ESTAT_ECODE_LSB +: 6] : ecode_q;
      esub_d  = (csr_we && (csr_num == CSR_ESTAT)) ? wr_s[ESTAT_ESUB_LSB +: 9] : esub_q;
    end
    badv_d   = (wb_ex && wb_badv_we) ? wb_vaddr :
               ((csr_we && (csr_num == CSR_BADV)) ? wr_s : badv_q);
    lie_d    = (csr_we && (csr_num == CSR_ECFG)) ? (wr_s[12:0] & ECFG_LIE_MASK) : lie_q;
    is_sw_d  = (csr_we && (csr_num == CSR_ESTAT)) ? wr_s[ESTAT_SWI_LSB +: 2] : is_sw_q;
    eentry_d = (csr_we && (csr_num == CSR_EENTRY)) ? wr_s[31:EENTRY_VA_LSB] : eentry_q;
    tid_d    = (csr_we && (csr_num == CSR_TID)) ? wr_s : tid_q;
    for (int i = 0; i < SAVE_NUM; i++) begin
      save_d[i] = (csr_we && (csr_num == (CSR_SAVE0 + 14'(i)))) ? wr_s : save_q[i];
    end
  end

  // CSR state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q   <= '{ie: 1'b0, plv: 2'b00};
      prmd_q   <= '{ie: 1'b0, plv: 2'b00};
      lie_q    <= 13'h0;
      is_sw_q  <= 2'b00;
      hwi_q    <= {HW_INT_NUM{1'b0}};
      ipi_q    <= 1'b0;
      ecode_q  <= 6'h0;
      esub_q   <= 9'h0;
      era_q    <= 32'h0;
      badv_q   <= 32'h0;
      eentry_q <= 26'h0;
      tid_q    <= CORE_ID;
      for (int i = 0; i < SAVE_NUM; i++) begin
        save_q[i] <= 32'h0;
      end
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      lie_q    <= lie_d;
      is_sw_q  <= is_sw_d;
      hwi_q    <= hwi_d;
      ipi_q    <= ipi_d;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      for (int i = 0; i < SAVE_NUM; i++) begin
        save_q[i] <= save_d[i];
      end
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed self-checking bench for csr_ctrl with a queue-based expected-value scoreboard.
module tb_csr_ctrl;
  import csr_pkg::*;

  logic        clk;
  logic        rst;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [1:0]  hw_int_in;
  logic        ipi_int_in;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        wb_badv_we;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        has_int;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  csr_ctrl #(
    .HW_INT_NUM (2),
    .TIMER_WIDTH(32),
    .SAVE_NUM   (4),
    .CORE_ID    (32'h0000_005A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_re     (csr_re),
    .csr_num    (csr_num),
    .csr_rvalue (csr_rvalue),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .wb_ex      (wb_ex),
    .wb_ecode   (wb_ecode),
    .wb_esubcode(wb_esubcode),
    .wb_pc      (wb_pc),
    .wb_badv_we (wb_badv_we),
    .wb_vaddr   (wb_vaddr),
    .ertn_flush (ertn_flush),
    .ex_entry   (ex_entry),
    .ertn_pc    (ertn_pc),
    .has_int    (has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd_chk(input logic [13:0] num, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    sb_check(csr_rvalue);
  endtask

  task automatic ti_chk(input logic exp, input string tag);
    sb_push(tag, {31'h0, exp});
    csr_re  = 1'b1;
    csr_num = CSR_ESTAT;
    #1;
    sb_check({31'h0, csr_rvalue[11]});
  endtask

  task automatic port_chk(input int which, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    #1;
    case (which)
      0:       sb_check({31'h0, has_int});
      1:       sb_check(ex_entry);
      default: sb_check(ertn_pc);
    endcase
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    step();
    csr_we     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csr_re = 1'b0; csr_num = 14'h0; csr_we = 1'b0;
    csr_wmask = 32'h0; csr_wvalue = 32'h0; hw_int_in = 2'b00; ipi_int_in = 1'b0;
    wb_ex = 1'b0; wb_ecode = 6'h0; wb_esubcode = 9'h0; wb_pc = 32'h0;
    wb_badv_we = 1'b0; wb_vaddr = 32'h0; ertn_flush = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    rd_chk(CSR_CRMD,   32'h0000_0008, "rst_crmd");
    rd_chk(CSR_PRMD,   32'h0,         "rst_prmd");
    rd_chk(CSR_ECFG,   32'h0,         "rst_ecfg");
    rd_chk(CSR_ESTAT,  32'h0,         "rst_estat");
    rd_chk(CSR_ERA,    32'h0,         "rst_era");
    rd_chk(CSR_EENTRY, 32'h0,         "rst_eentry");
    rd_chk(CSR_TCFG,   32'h0,         "rst_tcfg");
    rd_chk(CSR_TVAL,   32'h0,         "rst_tval");
    rd_chk(CSR_TID,    32'h0000_005A, "rst_tid");
    rd_chk(CSR_SAVE0,  32'h0,         "rst_save0");
    port_chk(0, 32'h0, "rst_has_int");
    step();

    // Masked CRMD write, then PLV=3 IE=1
    wr(CSR_CRMD, 32'h3, 32'h7);
    rd_chk(CSR_CRMD, 32'h0000_000B, "crmd_masked");
    wr(CSR_CRMD, 32'h7, 32'h7);
    rd_chk(CSR_CRMD, 32'h0000_000F, "crmd_plv3_ie");

    // Exception commit against a competing CRMD write
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100;
    wb_badv_we = 1'b1; wb_vaddr = 32'hDEAD_0000;
    csr_we = 1'b1; csr_num = CSR_CRMD; csr_wmask = 32'h7; csr_wvalue = 32'h7;
    step();
    wb_ex = 1'b0; wb_badv_we = 1'b0; csr_we = 1'b0;
    rd_chk(CSR_PRMD,  32'h0000_0007, "ex_prmd");
    rd_chk(CSR_CRMD,  32'h0000_0008, "ex_crmd");
    rd_chk(CSR_ERA,   32'h1C00_0100, "ex_era");
    rd_chk(CSR_BADV,  32'hDEAD_0000, "ex_badv");
    rd_chk(CSR_ESTAT, 32'h000B_0000, "ex_estat");
    port_chk(2, 32'h1C00_0100, "ex_ertn_pc");

    // ertn against a competing CRMD write of zero
    ertn_flush = 1'b1;
    csr_we = 1'b1; csr_num = CSR_CRMD; csr_wmask = 32'h7; csr_wvalue = 32'h0;
    step();
    ertn_flush = 1'b0; csr_we = 1'b0;
    rd_chk(CSR_CRMD, 32'h0000_000F, "ertn_crmd");

    // Second exception without BADV update, full Ecode/EsubCode
    wb_ex = 1'b1; wb_ecode = 6'h3F; wb_esubcode = 9'h1FF; wb_pc = 32'h1C00_0200;
    wb_vaddr = 32'h1111_1111;
    step();
    wb_ex = 1'b0;
    rd_chk(CSR_BADV,  32'hDEAD_0000, "ex2_badv_hold");
    rd_chk(CSR_ESTAT, 32'h7FFF_0000, "ex2_estat");
    ertn_flush = 1'b1;
    step();
    ertn_flush = 1'b0;
    rd_chk(CSR_CRMD, 32'h0000_000F, "ertn2_crmd");
    wr(CSR_ESTAT, 32'h7FFF_0000, 32'h000B_0000);
    rd_chk(CSR_ESTAT, 32'h000B_0000, "estat_sw_ecode");

    // EENTRY, SAVEn, TID, unimplemented and disabled reads
    wr(CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_chk(CSR_EENTRY, 32'hFFFF_FFC0, "eentry_low0");
    port_chk(1, 32'hFFFF_FFC0, "ex_entry");
    wr(CSR_SAVE0 + 14'h3, 32'hFFFF_FFFF, 32'h1234_5678);
    rd_chk(CSR_SAVE0 + 14'h3, 32'h1234_5678, "save3");
    wr(CSR_SAVE0 + 14'h4, 32'hFFFF_FFFF, 32'hAAAA_5555);
    rd_chk(CSR_SAVE0 + 14'h4, 32'h0, "save4_unimpl");
    rd_chk(CSR_SAVE0, 32'h0, "save0_untouched");
    wr(CSR_TID, 32'hFFFF_0000, 32'hCAFE_F00D);
    rd_chk(CSR_TID, 32'hCAFE_005A, "tid_masked");
    rd_chk(14'h002, 32'h0, "unimpl_0x2");
    rd_chk(CSR_TICLR, 32'h0, "ticlr_read");
    sb_push("re_low", 32'h0);
    csr_re = 1'b0; csr_num = CSR_CRMD;
    #1;
    sb_check(csr_rvalue);
    step();

    // Interrupts
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_1FFF);
    rd_chk(CSR_ECFG, 32'h0000_1BFF, "ecfg_mask");
    hw_int_in = 2'b11;
    step();
    rd_chk(CSR_ESTAT, 32'h000B_000C, "estat_hwi");
    port_chk(0, 32'h1, "has_int_on");
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0);
    port_chk(0, 32'h0, "has_int_lie0");
    hw_int_in = 2'b00; ipi_int_in = 1'b1;
    step();
    rd_chk(CSR_ESTAT, 32'h000B_1000, "estat_ipi");
    ipi_int_in = 1'b0;
    wr(CSR_ESTAT, 32'h3, 32'h3);
    rd_chk(CSR_ESTAT, 32'h000B_0003, "estat_swi");
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h1);
    port_chk(0, 32'h1, "has_int_swi");
    wr(CSR_ESTAT, 32'h3, 32'h0);
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0);

    // One-shot timer, InitVal=4
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
    rd_chk(CSR_TCFG, 32'h11, "oneshot_tcfg");
    for (int i = 0; i <= 16; i++) begin
      rd_chk(CSR_TVAL, 32'(16 - i), "oneshot_tval");
      ti_chk(i == 16, "oneshot_ti");
      step();
    end
    repeat (3) begin
      rd_chk(CSR_TVAL, 32'h0, "oneshot_hold0");
      step();
    end
    wr(CSR_TICLR, 32'h1, 32'h1);
    ti_chk(1'b0, "ticlr_clear");
    repeat (5) step();
    ti_chk(1'b0, "oneshot_no_refire");

    // Periodic timer, InitVal=2 -> period 9
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0B);
    repeat (7) step();
    rd_chk(CSR_TVAL, 32'h1, "per_tval1");
    ti_chk(1'b0, "per_ti_before");
    wr(CSR_TICLR, 32'h1, 32'h1);
    ti_chk(1'b1, "per_set_beats_clr");
    rd_chk(CSR_TVAL, 32'h0, "per_tval0");
    step();
    rd_chk(CSR_TVAL, 32'h8, "per_reload");
    wr(CSR_TICLR, 32'h1, 32'h1);
    ti_chk(1'b0, "per_cleared");
    rd_chk(CSR_TVAL, 32'h7, "per_tval7");
    repeat (6) step();
    rd_chk(CSR_TVAL, 32'h1, "per2_tval1");
    ti_chk(1'b0, "per2_ti_before");
    step();
    ti_chk(1'b1, "per2_ti_set");
    step();
    rd_chk(CSR_TVAL, 32'h8, "per2_reload");

    // Periodic with InitVal=0 never fires
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h3);
    wr(CSR_TICLR, 32'h1, 32'h1);
    repeat (6) step();
    rd_chk(CSR_TVAL, 32'h0, "init0_tval");
    ti_chk(1'b0, "init0_no_fire");
    rd_chk(CSR_TCFG, 32'h3, "init0_tcfg");

    // Reset in the middle of a count
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
    repeat (11) step();
    rd_chk(CSR_TVAL, 32'h5, "pre_rst_tval5");
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_chk(CSR_TVAL, 32'h0, "rst_mid_tval");
      rd_chk(CSR_TCFG, 32'h0, "rst_mid_tcfg");
      ti_chk(1'b0, "rst_mid_ti");
      step();
    end
    rd_chk(CSR_TID,  32'h0000_005A, "rst_mid_tid");
    rd_chk(CSR_CRMD, 32'h0000_0008, "rst_mid_crmd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 SHALL have parameter HW_INT_NUM, default 8, number of hardware interrupt lines (1..8) mapped to ESTAT.IS[2+HW_INT_NUM-1:2].
REQ-002 SHALL have parameter TIMER_WIDTH, default 32, timer counter width (8..32); TCFG.InitVal occupies bits [TIMER_WIDTH-1:2].
REQ-003 SHALL have parameter SAVE_NUM, default 4, number of SAVEn scratch registers (1..16), SAVE0 at 0x30.
REQ-004 SHALL have parameter CORE_ID, default 32'h0, reset value of TID.
REQ-005 SHALL use one clock and a synchronous active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have csr_re  in  1  read enable; csr_num  in  14  register number; csr_rvalue  out  32  read data.
REQ-007 SHALL have csr_we  in  1  write enable; csr_wmask  in  32  per-bit write mask; csr_wvalue  in  32  write data.
REQ-008 SHALL have hw_int_in  in  HW_INT_NUM  level hardware interrupts; ipi_int_in  in  1  inter-processor interrupt.
REQ-009 SHALL have wb_ex  in  1  exception commit; wb_ecode  in  6  Ecode; wb_esubcode  in  9  EsubCode; wb_pc  in  32  faulting PC; wb_badv_we  in  1  BADV update; wb_vaddr  in  32  faulting address.
REQ-010 SHALL have ertn_flush  in  1  ertn commit; ex_entry  out  32  EENTRY value; ertn_pc  out  32  ERA value; has_int  out  1  pending enabled interrupt.

Function
REQ-011 SHALL implement CRMD(0x0), PRMD(0x1), ECFG(0x4), ESTAT(0x5), ERA(0x6), BADV(0x7), EENTRY(0xC), SAVE0..SAVE_NUM-1, TID(0x40), TCFG(0x41), TVAL(0x42), TICLR(0x44).
REQ-012 Every software write SHALL update bit i to wvalue[i] where wmask[i]=1, else hold; read-only bits ignore writes.
REQ-013 csr_rvalue SHALL be combinational; 0 when csr_re=0 or csr_num unimplemented (incl. SAVEn with n>=SAVE_NUM).
REQ-014 CRMD.DA SHALL read 1, PG/DATF/DATM 0; CRMD.PLV/IE writable.
REQ-015 Update priority per cycle SHALL be wb_ex > ertn_flush > software write for CRMD, PRMD, ERA, ESTAT.Ecode/EsubCode.
REQ-016 On wb_ex: PRMD.PPLV/PIE <= CRMD.PLV/IE; CRMD.PLV<=0, IE<=0; ERA<=wb_pc; Ecode/EsubCode latched; BADV<=wb_vaddr only if wb_badv_we.
REQ-017 On ertn_flush: CRMD.PLV/IE <= PRMD.PPLV/PIE.
REQ-018 ECFG.LIE SHALL be masked with 13'h1bff; EENTRY[5:0] SHALL read 0.
REQ-019 ESTAT.IS[1:0] software-writable; IS[2+k] registered from hw_int_in[k]; IS bits for k>=HW_INT_NUM and IS[10] read 0; IS[12] registered from ipi_int_in.
REQ-020 has_int SHALL equal CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational.
REQ-021 TCFG write SHALL load counter with {InitVal,2'b00} and set En/Periodic per written bits, same edge.
REQ-022 Counter SHALL decrement by 1 per cycle while En=1 and counter!=0.
REQ-023 On counter transition 1->0, ESTAT.IS[11] SHALL set on the same edge.
REQ-024 When En=1, counter=0: Periodic=1 -> reload {InitVal,2'b00} next cycle; Periodic=0 -> hold 0, no further IS[11] set.
REQ-025 InitVal=0 with Periodic=1 SHALL not retrigger (no reload-to-zero storm).
REQ-026 TICLR write with wmask[0]&wvalue[0] SHALL clear IS[11]; a simultaneous timer set SHALL win; TICLR reads 0.
REQ-027 TVAL SHALL read counter zero-extended to 32 bits; TID resets to CORE_ID and is writable.
REQ-028 ex_entry SHALL equal EENTRY, ertn_pc SHALL equal ERA, both combinational.

Reset
REQ-029 On rst: CRMD.PLV=0, IE=0; ECFG.LIE=0; ESTAT.IS=0; TCFG.En=0; counter=0; TID=CORE_ID; reset mid-count SHALL stop the timer with no IS[11] set.
REQ-030 PRMD, ERA, BADV, EENTRY, SAVEn, Ecode SHALL reset to 0 (deterministic for simulation).

Structure
REQ-031 CSR numbers, field bit positions and the 13'h1bff mask SHALL live in shared package csr_pkg.
REQ-032 Timer (TCFG, counter, IS[11] set/clear) SHALL be sub-module csr_timer parametrised by TIMER_WIDTH.

Verification
REQ-033 Masked write: CRMD wmask=0x3, wvalue=0x7 -> CRMD.PLV=3, IE=0; read returns 0x0000000B.
REQ-034 Exception+ertn: PLV=3,IE=1, wb_ex with ecode=0x0B, wb_pc=0x1C000100 -> PRMD=0x7, CRMD.PLV/IE=0, ERA=0x1C000100; ertn_flush -> PLV=3, IE=1.
REQ-035 One-shot timer: TCFG=0x11 (InitVal=4,En) -> TVAL 16..0, IS[11]=1 exactly 16 cycles after write, TVAL stays 0.
REQ-036 Periodic timer: TCFG=0x0B -> IS[11] set every 9 cycles; TICLR write on set cycle leaves IS[11]=1.
REQ-037 Interrupts: HW_INT_NUM=2, hw_int_in=2'b11, LIE=0x1FFF, IE=1 -> ESTAT.IS=0x00C, has_int=1; LIE=0 -> has_int=0.
REQ-038 Reset mid-count: rst during TVAL=5 -> TVAL=0, En=0, IS[11]=0 for 20 cycles.
